// File: rtl/usb_pkg.sv
// Shared USB transmit-path types, sizes, CRC polynomials and the serial CRC update step.
package usb_pkg;

  typedef enum logic [1:0] {
    DATA   = 2'd0,
    TOKEN  = 2'd1,
    HSHAKE = 2'd2
  } pkt_t;

  typedef enum logic [2:0] {
    IDLE,
    HDR,
    BODY,
    DRAIN,
    CRC_OUT
  } state_t;

  localparam logic [7:0] SYNC = 8'b0000_0001;

  localparam int unsigned DATA_CRC_BITS     = 16;
  localparam int unsigned TOKEN_CRC_BITS    = 5;
  localparam int unsigned HSHAKE_CRC_BITS   = 0;
  localparam int unsigned TOKEN_FIELD_BITS  = 11;
  localparam int unsigned HSHAKE_FIELD_BITS = 0;

  localparam logic [4:0]  POLY5  = 5'b00101;
  localparam logic [15:0] POLY16 = 16'h8005;

  localparam logic [4:0]  CRC5_INIT  = 5'h1F;
  localparam logic [15:0] CRC16_INIT = 16'hFFFF;

  localparam logic [4:0]  CRC5_RESIDUE  = 5'b01100;
  localparam logic [15:0] CRC16_RESIDUE = 16'h800D;

  // One serial CRC step; TOKEN uses the low 5 bits and keeps the upper bits clear.
  function automatic logic [15:0] crc_step(input pkt_t t, input logic [15:0] crc, input logic b);
    logic fb;
    if (t == TOKEN) begin
      fb = b ^ crc[4];
      return {11'd0, {crc[3:0], 1'b0} ^ (fb ? POLY5 : 5'd0)};
    end
    fb = b ^ crc[15];
    return {crc[14:0], 1'b0} ^ (fb ? POLY16 : 16'd0);
  endfunction

endpackage

// File: rtl/fifo.sv
// 1-bit elastic buffer between the encoder and the bit stuffer; DEPTH must be a power of two.
module fifo #(
  parameter int unsigned DEPTH = 32
) (
  input  logic clk,
  input  logic rst_b,
  input  logic wr,
  input  logic din,
  input  logic rd,
  output logic dout,
  output logic full,
  output logic empty,
  output logic single
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  logic [DEPTH-1:0] mem_q;
  logic [AW-1:0]    wptr_q, rptr_q;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             do_wr, do_rd;

  assign empty  = cnt_q == '0;
  assign full   = cnt_q == CW'(DEPTH);
  assign single = cnt_q == CW'(1);
  assign dout   = mem_q[rptr_q];
  assign do_rd  = rd && !empty;
  // A pop in the same cycle frees the slot, so a write to a full FIFO is still legal then.
  assign do_wr  = wr && (!full || do_rd);

  always_comb begin
    cnt_d = cnt_q;
    case ({do_wr, do_rd})
      2'b10:   cnt_d = cnt_q + CW'(1);
      2'b01:   cnt_d = cnt_q - CW'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      mem_q  <= '0;
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
    end else begin
      cnt_q <= cnt_d;
      if (do_wr) begin
        mem_q[wptr_q] <= din;
        wptr_q        <= wptr_q + AW'(1);
      end
      if (do_rd) begin
        rptr_q <= rptr_q + AW'(1);
      end
    end
  end

endmodule

// File: rtl/usb_crc_ctrl.sv
// Transmit-path sequencer: buffers the packet bit stream and appends a complemented CRC5/CRC16.
// Define CRC_ERR_EN to build the sticky protocol-error flag; otherwise err is tied low.
module usb_crc_ctrl
  import usb_pkg::*;
#(
  parameter int unsigned DEPTH    = 32,
  parameter int unsigned HDR_BITS = 16
) (
  input  logic       clk,
  input  logic       rst_b,
  input  logic       s_in,
  input  logic       start,
  input  logic       endr,
  input  logic [1:0] pkt_type,
  input  logic       pause,
  output logic       s_out,
  output logic       start_b,
  output logic       endr_b,
  output logic       busy,
  output logic       err
);

  localparam int unsigned   CW         = $clog2(HDR_BITS) + 1;
  localparam logic [CW-1:0] HDR_LAST   = CW'(HDR_BITS - 1);
  localparam logic [3:0]    TOKEN_LAST = 4'(TOKEN_CRC_BITS - 1);
  localparam logic [3:0]    DATA_LAST  = 4'(DATA_CRC_BITS - 1);

  state_t        state_q, state_d;
  pkt_t          type_q, type_d;
  logic [15:0]   crc_q, crc_d;
  logic [15:0]   rem_q, rem_d;
  logic [15:0]   crc_nxt;
  logic          crc_en_q, crc_en_d;
  logic          first_q, first_d;
  logic [CW-1:0] in_cnt_q, in_cnt_d;
  logic [3:0]    out_cnt_q, out_cnt_d;

  logic wr_req, f_wr, f_head, f_full, f_empty, f_single;
  logic pop, crc_last;

  assign pop      = !pause && !f_empty;
  assign f_wr     = wr_req && (!f_full || pop);
  assign crc_nxt  = crc_step(type_q, crc_q, s_in);
  assign crc_last = out_cnt_q == ((type_q == TOKEN) ? TOKEN_LAST : DATA_LAST);

  fifo #(
    .DEPTH(DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_b (rst_b),
    .wr    (f_wr),
    .din   (s_in),
    .rd    (pop),
    .dout  (f_head),
    .full  (f_full),
    .empty (f_empty),
    .single(f_single)
  );

  always_comb begin
    state_d   = state_q;
    type_d    = type_q;
    crc_d     = crc_q;
    rem_d     = rem_q;
    crc_en_d  = crc_en_q;
    first_d   = first_q;
    in_cnt_d  = in_cnt_q;
    out_cnt_d = out_cnt_q;
    wr_req    = 1'b0;

    if (pop) begin
      first_d = 1'b0;
    end

    unique case (state_q)
      IDLE: begin
        if (start && !endr) begin
          type_d    = pkt_t'(pkt_type);
          crc_d     = (pkt_t'(pkt_type) == TOKEN) ? {11'd0, CRC5_INIT} : CRC16_INIT;
          crc_en_d  = 1'b0;
          first_d   = 1'b1;
          in_cnt_d  = CW'(1);
          out_cnt_d = '0;
          wr_req    = 1'b1;
          state_d   = HDR;
        end
      end
      HDR: begin
        wr_req   = 1'b1;
        in_cnt_d = in_cnt_q + CW'(1);
        if (in_cnt_q == HDR_LAST) begin
          if (endr) begin
            // Zero-length field: the appended CRC is the complemented init value.
            rem_d    = ~crc_q;
            crc_en_d = type_q != HSHAKE;
            state_d  = DRAIN;
          end else begin
            state_d = BODY;
          end
        end else if (endr) begin
          crc_en_d = 1'b0;
          state_d  = DRAIN;
        end
      end
      BODY: begin
        wr_req = 1'b1;
        crc_d  = crc_nxt;
        if (endr) begin
          rem_d    = ~crc_nxt;
          crc_en_d = type_q != HSHAKE;
          state_d  = DRAIN;
        end
      end
      DRAIN: begin
        if (f_empty || (pop && f_single)) begin
          state_d = crc_en_q ? CRC_OUT : IDLE;
        end
      end
      CRC_OUT: begin
        if (!pause) begin
          rem_d     = {rem_q[14:0], 1'b0};
          out_cnt_d = out_cnt_q + 4'd1;
          if (crc_last) begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      state_q   <= IDLE;
      type_q    <= DATA;
      crc_q     <= '0;
      rem_q     <= '0;
      crc_en_q  <= 1'b0;
      first_q   <= 1'b0;
      in_cnt_q  <= '0;
      out_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      type_q    <= type_d;
      crc_q     <= crc_d;
      rem_q     <= rem_d;
      crc_en_q  <= crc_en_d;
      first_q   <= first_d;
      in_cnt_q  <= in_cnt_d;
      out_cnt_q <= out_cnt_d;
    end
  end

  always_comb begin
    s_out = f_head && !f_empty;
    if (state_q == CRC_OUT) begin
      s_out = (type_q == TOKEN) ? rem_q[4] : rem_q[15];
    end
  end

  assign start_b = first_q && !f_empty;
  assign endr_b  = (state_q == CRC_OUT && crc_last) ||
                   (state_q == DRAIN && f_single && !crc_en_q);
  assign busy    = state_q != IDLE;

`ifdef CRC_ERR_EN
  logic err_q, err_d;

  always_comb begin
    err_d = err_q;
    if (state_q == IDLE && start && !endr) begin
      err_d = 1'b0;
    end
    if ((start && (state_q != IDLE || endr)) ||
        (wr_req && f_full && !pop) ||
        (state_q == HDR && endr && in_cnt_q != HDR_LAST)) begin
      err_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      err_q <= 1'b0;
    end else begin
      err_q <= err_d;
    end
  end

  assign err = err_q;
`else
  assign err = 1'b0;
`endif

endmodule

// File: tb/tb_usb_crc_ctrl.sv
// Directed packet bench for usb_crc_ctrl with a bit-level output scoreboard and CRC residue checks.
module tb_usb_crc_ctrl;

  logic       clk = 1'b0;
  logic       rst_b = 1'b1;
  logic       s_in = 1'b0;
  logic       start = 1'b0;
  logic       endr = 1'b0;
  logic [1:0] pkt_type = 2'd0;
  logic       pause = 1'b0;
  logic       s_out, start_b, endr_b, busy, err;

  always #5 clk = ~clk;

  usb_crc_ctrl dut (
    .clk     (clk),
    .rst_b   (rst_b),
    .s_in    (s_in),
    .start   (start),
    .endr    (endr),
    .pkt_type(pkt_type),
    .pause   (pause),
    .s_out   (s_out),
    .start_b (start_b),
    .endr_b  (endr_b),
    .busy    (busy),
    .err     (err)
  );

`ifdef CRC_ERR_EN
  localparam logic ERR_ON = 1'b1;
`else
  localparam logic ERR_ON = 1'b0;
`endif

  typedef struct packed {
    logic b;
    logic first;
    logic last;
  } exp_t;

  exp_t sb[$];
  logic obs_bits[$];
  logic pkt[0:127];
  int   n_vec = 0;
  int   n_fail = 0;
  int   cyc = 0;
  int   pmode = 0;
  int   p_from = 0;
  int   p_len = 0;
  logic in_pkt = 1'b0;
  logic chk_on = 1'b1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] crc_upd(input int w, input logic [15:0] c, input logic b);
    logic fb;
    if (w == 5) begin
      fb = b ^ c[4];
      return {11'd0, {c[3:0], 1'b0} ^ (fb ? 5'b00101 : 5'b00000)};
    end
    fb = b ^ c[15];
    return {c[14:0], 1'b0} ^ (fb ? 16'h8005 : 16'h0000);
  endfunction

  function automatic logic pause_at(input int c);
    case (pmode)
      1:       return (c % 8) < 3;
      2:       return (c >= p_from) && (c < p_from + p_len);
      default: return 1'b0;
    endcase
  endfunction

  task automatic push(input logic b, input logic f, input logic l);
    exp_t e;
    e.b = b;
    e.first = f;
    e.last = l;
    sb.push_back(e);
  endtask

  // Consumer side: a bit is taken whenever pause is low and a packet bit is presented.
  task automatic monitor(input logic pz);
    exp_t e;
    if (!chk_on || pz) return;
    if (!in_pkt && start_b !== 1'b1) return;
    obs_bits.push_back(s_out);
    if (sb.size() == 0) begin
      chk("sb_underflow", 32'(sb.size()), 32'd1);
      in_pkt = 1'b0;
      return;
    end
    e = sb.pop_front();
    chk("s_out", s_out, e.b);
    chk("start_b", start_b, e.first);
    chk("endr_b", endr_b, e.last);
    in_pkt = !e.last;
  endtask

  task automatic step(input logic b, input logic st, input logic en);
    logic pz;
    pz = pause_at(cyc);
    s_in = b;
    start = st;
    endr = en;
    pause = pz;
    #1;
    monitor(pz);
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic drain();
    int k;
    k = 0;
    while (((chk_on && sb.size() != 0) || busy) && k < 400) begin
      step(1'b0, 1'b0, 1'b0);
      k++;
    end
    chk("drain_sb", 32'(sb.size()), 32'd0);
    chk("idle_busy", busy, 1'b0);
  endtask

  task automatic set_byte(input int pos, input logic [7:0] v);
    for (int i = 0; i < 8; i++) pkt[pos + i] = v[i];
  endtask

  task automatic send(input logic [1:0] typ, input int n);
    int          w;
    logic [15:0] c;
    w = (typ == 2'd1) ? 5 : 16;
    c = (typ == 2'd1) ? 16'h001F : 16'hFFFF;
    cyc = 0;
    in_pkt = 1'b0;
    obs_bits.delete();
    pkt_type = typ;
    for (int i = 0; i < n; i++) begin
      if (chk_on) push(pkt[i], i == 0, (typ == 2'd2) && (i == n - 1));
      if (i >= 16) c = crc_upd(w, c, pkt[i]);
      step(pkt[i], i == 0, i == n - 1);
      if (i == 0) begin
        chk("busy_rise", busy, 1'b1);
        chk("err_clr", err, 1'b0);
      end
    end
    if (chk_on && typ != 2'd2) begin
      for (int k = w - 1; k >= 0; k--) push(~c[k], 1'b0, k == 0);
    end
    drain();
    if (chk_on) begin
      chk("out_len", 32'(obs_bits.size()), 32'(n + ((typ == 2'd2) ? 0 : w)));
      if (typ != 2'd2) begin
        c = (typ == 2'd1) ? 16'h001F : 16'hFFFF;
        for (int i = 16; i < obs_bits.size(); i++) c = crc_upd(w, c, obs_bits[i]);
        chk("residue", c, (typ == 2'd1) ? 32'h0000_000C : 32'h0000_800D);
      end
    end
  endtask

  initial begin
    logic [10:0] field;

    // Reset state
    #2 rst_b = 1'b0;
    #1;
    chk("rst_s_out", s_out, 1'b0);
    chk("rst_start_b", start_b, 1'b0);
    chk("rst_endr_b", endr_b, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_err", err, 1'b0);
    @(posedge clk);
    #1 rst_b = 1'b1;
    @(posedge clk);
    #1;

    // Zero-length DATA0
    pmode = 0;
    set_byte(0, 8'b0000_0001);
    set_byte(8, 8'b1100_0011);
    send(2'd0, 16);

    // ACK handshake passes through untouched
    set_byte(8, 8'b1101_0010);
    send(2'd2, 16);

    // IN token, 11-bit field 0x3A5 sent LSB first
    set_byte(8, 8'b0110_1001);
    field = 11'h3A5;
    for (int i = 0; i < 11; i++) pkt[16 + i] = field[i];
    send(2'd1, 27);

    // DATA1 with 64-bit payload and pause 3 of every 8 cycles
    pmode = 1;
    set_byte(8, 8'b0100_1011);
    for (int i = 16; i < 80; i++) pkt[i] = 1'($urandom_range(0, 1));
    send(2'd0, 80);
    chk("err_after_pause", err, 1'b0);

    // start together with endr in IDLE is ignored
    pmode = 0;
    cyc = 0;
    pkt_type = 2'd0;
    step(1'b0, 1'b1, 1'b1);
    chk("start_endr_busy", busy, 1'b0);
    chk("start_endr_err", err, ERR_ON);
    step(1'b0, 1'b0, 1'b0);

    // 40-cycle pause mid-body overflows the FIFO
    chk_on = 1'b0;
    pmode = 2;
    p_from = 26;
    p_len = 40;
    set_byte(8, 8'b1100_0011);
    for (int i = 16; i < 80; i++) pkt[i] = 1'($urandom_range(0, 1));
    send(2'd0, 80);
    chk("ovf_err", err, ERR_ON);
    chk_on = 1'b1;
    pmode = 0;

    // Next packet clears err and is intact
    set_byte(8, 8'b1101_0010);
    send(2'd2, 16);
    chk("err_cleared", err, 1'b0);

    // Reset mid-body discards everything at once
    chk_on = 1'b0;
    cyc = 0;
    pkt_type = 2'd0;
    set_byte(8, 8'b1100_0011);
    for (int i = 16; i < 80; i++) pkt[i] = 1'($urandom_range(0, 1));
    for (int i = 0; i < 40; i++) step(pkt[i], i == 0, 1'b0);
    rst_b = 1'b0;
    #1;
    chk("mid_rst_s_out", s_out, 1'b0);
    chk("mid_rst_start_b", start_b, 1'b0);
    chk("mid_rst_endr_b", endr_b, 1'b0);
    chk("mid_rst_busy", busy, 1'b0);
    chk("mid_rst_err", err, 1'b0);
    @(posedge clk);
    #1 rst_b = 1'b1;
    sb.delete();
    in_pkt = 1'b0;
    chk_on = 1'b1;

    // Token after reset
    set_byte(8, 8'b0110_1001);
    field = 11'h3A5;
    for (int i = 0; i < 11; i++) pkt[16 + i] = field[i];
    send(2'd1, 27);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
